// File: rtl/alu_fns_pkg.sv
// ALU_FNS: ALU function encodings shared by the alu and its callers.
// The encoding is the RISC-V funct3 value, so decode can cast funct3 directly.
package ALU_FNS;

    typedef enum logic [2:0] {
        ADD_SUB = 3'b000,
        SLL     = 3'b001,
        SLT     = 3'b010,
        SLTU    = 3'b011,
        XOR     = 3'b100,
        SRL_SRA = 3'b101,
        OR      = 3'b110,
        AND     = 3'b111
    } ALU_FN_t;

endpackage

// File: rtl/rv_pkg.sv
// rv_pkg: RV32I opcode map for the integer ops handled by the execute stage,
// plus the funct7 value that selects SUB / SRA.
package rv_pkg;

    typedef enum logic [6:0] {
        OP     = 7'b0110011,
        OP_IMM = 7'b0010011,
        LUI    = 7'b0110111,
        AUIPC  = 7'b0010111
    } opcode_t;

    localparam logic [6:0] F7_SUB_SRA = 7'h20;

endpackage

// File: rtl/alu.sv
// alu: combinational integer ALU.
// Ports:
//   fn     - function select (ALU_FN_t)
//   funct7 - 7'h20 selects SUB for ADD_SUB and SRA for SRL_SRA
//   a, b   - operands; shifts use b[$clog2(WIDTH)-1:0]
//   result - WIDTH-bit result
module alu
    import ALU_FNS::*;
    import rv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  ALU_FN_t            fn,
    input  logic [6:0]         funct7,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [WIDTH-1:0]   result
);
    localparam int SH_W = $clog2(WIDTH);

    logic            alt;
    logic [SH_W-1:0] shamt;

    assign alt   = (funct7 == F7_SUB_SRA);
    assign shamt = b[SH_W-1:0];

    always_comb begin
        result = '0;
        unique case (fn)
            ADD_SUB: result = alt ? (a - b) : (a + b);
            SLL:     result = a << shamt;
            SLT:     result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            SLTU:    result = {{(WIDTH-1){1'b0}}, (a < b)};
            XOR:     result = a ^ b;
            SRL_SRA: begin
                if (alt) result = $unsigned($signed(a) >>> shamt);
                else     result = a >> shamt;
            end
            OR:      result = a | b;
            AND:     result = a & b;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/ex_decode.sv
// ex_decode: combinational decode for the execute stage.
// Ports:
//   opcode/funct3/funct7/rd        - instruction fields
//   rs1_val/rs2_val/imm/pc         - operand sources
//   fn/alu_funct7/alu_a/alu_b      - alu controls and operands
//   use_imm                        - result is imm (LUI), alu bypassed
//   illegal                        - opcode not supported here
//   wb_en                          - legal and rd != x0
module ex_decode
    import ALU_FNS::*;
    import rv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic [4:0]       rd,
    input  logic [WIDTH-1:0] rs1_val,
    input  logic [WIDTH-1:0] rs2_val,
    input  logic [WIDTH-1:0] imm,
    input  logic [WIDTH-1:0] pc,
    output ALU_FN_t          fn,
    output logic [6:0]       alu_funct7,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             use_imm,
    output logic             illegal,
    output logic             wb_en
);
    localparam int SH_W = $clog2(WIDTH);

    logic [WIDTH-1:0] b_raw;

    always_comb begin
        fn         = ALU_FN_t'(funct3);
        alu_funct7 = '0;
        alu_a      = rs1_val;
        b_raw      = rs2_val;
        use_imm    = 1'b0;
        illegal    = 1'b0;
        case (opcode)
            OP:     alu_funct7 = funct7;
            OP_IMM: begin
                b_raw = imm;
                // Only SRAI may carry 7'h20; ADDI with imm[30] set must not subtract.
                if (ALU_FN_t'(funct3) == SRL_SRA) alu_funct7 = funct7;
            end
            LUI:    use_imm = 1'b1;
            AUIPC:  begin
                fn    = ADD_SUB;
                alu_a = pc;
                b_raw = imm;
            end
            default: illegal = 1'b1;
        endcase
    end

    assign alu_b = ((fn == SLL) || (fn == SRL_SRA))
                 ? {{(WIDTH-SH_W){1'b0}}, b_raw[SH_W-1:0]}
                 : b_raw;

    assign wb_en = !illegal && (rd != 5'd0);

endmodule

// File: rtl/ex_stage.sv
// ex_stage: RISC-V integer execute stage.
// Decodes one instruction per cycle, runs it through the alu and registers
// the result toward writeback. A one-entry skid buffer behind the output
// register absorbs the accept that lands in the cycle out_ready drops.
// Ports:
//   clk, rst_n (async, active-low), flush (sync kill of held instructions)
//   in_valid/in_ready + in_* instruction fields from register read
//   out_valid/out_ready + out_result/out_rd/out_wb_en/out_illegal to writeback
module ex_stage
    import ALU_FNS::*;
    import rv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       in_opcode,
    input  logic [2:0]       in_funct3,
    input  logic [6:0]       in_funct7,
    input  logic [4:0]       in_rd,
    input  logic [WIDTH-1:0] in_rs1_val,
    input  logic [WIDTH-1:0] in_rs2_val,
    input  logic [WIDTH-1:0] in_imm,
    input  logic [WIDTH-1:0] in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [4:0]       out_rd,
    output logic             out_wb_en,
    output logic             out_illegal
);
    ALU_FN_t          dec_fn;
    logic [6:0]       dec_funct7;
    logic [WIDTH-1:0] dec_a, dec_b, alu_res, res_d;
    logic             dec_use_imm, dec_illegal, dec_wb_en;

    ex_decode #(.WIDTH(WIDTH)) u_decode (
        .opcode     (in_opcode),
        .funct3     (in_funct3),
        .funct7     (in_funct7),
        .rd         (in_rd),
        .rs1_val    (in_rs1_val),
        .rs2_val    (in_rs2_val),
        .imm        (in_imm),
        .pc         (in_pc),
        .fn         (dec_fn),
        .alu_funct7 (dec_funct7),
        .alu_a      (dec_a),
        .alu_b      (dec_b),
        .use_imm    (dec_use_imm),
        .illegal    (dec_illegal),
        .wb_en      (dec_wb_en)
    );

    alu #(.WIDTH(WIDTH)) u_alu (
        .fn     (dec_fn),
        .funct7 (dec_funct7),
        .a      (dec_a),
        .b      (dec_b),
        .result (alu_res)
    );

    assign res_d = dec_illegal ? '0 : (dec_use_imm ? in_imm : alu_res);

    logic             out_valid_q, out_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] out_result_q, skid_result_q;
    logic [4:0]       out_rd_q, skid_rd_q;
    logic             out_wb_en_q, skid_wb_en_q;
    logic             out_illegal_q, skid_illegal_q;
    logic             accept, load_out_new, load_out_skid, load_skid;

    // flush blocks the accept so a killed cycle never captures a new instruction.
    assign in_ready = !skid_valid_q && !flush;
    assign accept   = in_valid && in_ready;

    always_comb begin
        out_valid_d   = out_valid_q;
        skid_valid_d  = skid_valid_q;
        load_out_new  = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || out_ready) begin
            if (skid_valid_q) begin
                // Oldest entry is in skid; it goes first to keep FIFO order.
                load_out_skid = 1'b1;
                out_valid_d   = 1'b1;
                load_skid     = accept;
                skid_valid_d  = accept;
            end else begin
                load_out_new  = accept;
                out_valid_d   = accept;
            end
        end else if (accept) begin
            load_skid    = 1'b1;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q    <= 1'b0;
            skid_valid_q   <= 1'b0;
            out_result_q   <= '0;
            out_rd_q       <= '0;
            out_wb_en_q    <= 1'b0;
            out_illegal_q  <= 1'b0;
            skid_result_q  <= '0;
            skid_rd_q      <= '0;
            skid_wb_en_q   <= 1'b0;
            skid_illegal_q <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            if (load_out_skid) begin
                out_result_q  <= skid_result_q;
                out_rd_q      <= skid_rd_q;
                out_wb_en_q   <= skid_wb_en_q;
                out_illegal_q <= skid_illegal_q;
            end else if (load_out_new) begin
                out_result_q  <= res_d;
                out_rd_q      <= in_rd;
                out_wb_en_q   <= dec_wb_en;
                out_illegal_q <= dec_illegal;
            end
            if (load_skid) begin
                skid_result_q  <= res_d;
                skid_rd_q      <= in_rd;
                skid_wb_en_q   <= dec_wb_en;
                skid_illegal_q <= dec_illegal;
            end
        end
    end

    assign out_valid   = out_valid_q;
    assign out_result  = out_result_q;
    assign out_rd      = out_rd_q;
    assign out_wb_en   = out_wb_en_q;
    assign out_illegal = out_illegal_q;

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: scoreboard bench for ex_stage. The driver pushes the expected
// response of every accepted instruction; a monitor pops and compares on each
// output transfer.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [6:0]  in_opcode = '0;
    logic [2:0]  in_funct3 = '0;
    logic [6:0]  in_funct7 = '0;
    logic [4:0]  in_rd = '0;
    logic [31:0] in_rs1_val = '0, in_rs2_val = '0, in_imm = '0, in_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        out_wb_en;
    logic        out_illegal;

    ex_stage #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
        .in_rd(in_rd), .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
        .in_imm(in_imm), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_rd(out_rd), .out_wb_en(out_wb_en), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] result;
        logic [4:0]  rd;
        logic        wb_en;
        logic        illegal;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;
    bit   rdy_rand = 1'b0;
    bit   rdy_fix  = 1'b1;

    localparam logic [6:0] O_OP = 7'b0110011, O_IMM = 7'b0010011,
                           O_LUI = 7'b0110111, O_AUI = 7'b0010111,
                           O_LOAD = 7'b0000011;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference integer semantics of the RV32I ALU functions.
    function automatic logic [31:0] alu_ref(input logic [2:0] f3, input bit alt,
                                            input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        int unsigned sh;
        sh = b % 32;
        r  = 0;
        case (f3)
            3'd0: if (alt) r = a - b; else r = a + b;
            3'd1: r = a << sh;
            3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: r = (a < b) ? 32'd1 : 32'd0;
            3'd4: r = a ^ b;
            3'd5: if (alt) r = $signed(a) >>> sh; else r = a >> sh;
            3'd6: r = a | b;
            3'd7: r = a & b;
            default: r = 0;
        endcase
        return r;
    endfunction

    function automatic exp_t model(input logic [6:0] opc, input logic [2:0] f3,
                                   input logic [6:0] f7, input logic [4:0] rd,
                                   input logic [31:0] rs1, input logic [31:0] rs2,
                                   input logic [31:0] imm, input logic [31:0] pc);
        exp_t e;
        e.rd      = rd;
        e.illegal = 1'b0;
        e.result  = 0;
        case (opc)
            O_OP:  e.result = alu_ref(f3, f7 == 7'h20, rs1, rs2);
            O_IMM: e.result = alu_ref(f3, (f3 == 3'd5) && (f7 == 7'h20), rs1, imm);
            O_LUI: e.result = imm;
            O_AUI: e.result = pc + imm;
            default: e.illegal = 1'b1;
        endcase
        e.wb_en = !e.illegal && (rd != 0);
        return e;
    endfunction

    // Monitor: every output transfer must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            if (rst_n && out_valid && out_ready && !flush) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got result %h rd %0d, none expected", out_result, out_rd);
                end else begin
                    e = sbq.pop_front();
                    check("out_result", out_result, e.result);
                    check("out_rd_wb_ill", {27'd0, out_rd, out_wb_en, out_illegal},
                          {27'd0, e.rd, e.wb_en, e.illegal});
                end
            end
        end
    end

    task automatic cyc_setup();
        @(negedge clk);
        flush     = 1'b0;
        out_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_fix;
    endtask

    task automatic set_fields(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                              input logic [4:0] rd, input logic [31:0] rs1, input logic [31:0] rs2,
                              input logic [31:0] imm, input logic [31:0] pc);
        in_opcode = opc; in_funct3 = f3; in_funct7 = f7; in_rd = rd;
        in_rs1_val = rs1; in_rs2_val = rs2; in_imm = imm; in_pc = pc;
    endtask

    task automatic issue(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [4:0] rd, input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [31:0] imm, input logic [31:0] pc);
        for (int n = 0; n < 200; n++) begin
            cyc_setup();
            set_fields(opc, f3, f7, rd, rs1, rs2, imm, pc);
            in_valid = 1'b1;
            #4;
            if (in_ready) begin
                sbq.push_back(model(opc, f3, f7, rd, rs1, rs2, imm, pc));
                @(posedge clk);
                return;
            end
            @(posedge clk);
        end
        checks++;
        errors++;
        $display("FAIL issue_timeout: got in_ready 0 for 200 cycles, expected 1");
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            cyc_setup();
            in_valid = 1'b0;
            #4;
            @(posedge clk);
        end
    endtask

    task automatic drain();
        rdy_rand = 1'b0;
        rdy_fix  = 1'b1;
        for (int n = 0; n < 50 && sbq.size() != 0; n++) idle(1);
        if (sbq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d outstanding, expected 0", sbq.size());
            sbq.delete();
        end
        idle(1);
    endtask

    logic [6:0] opcs[5] = '{O_OP, O_IMM, O_LUI, O_AUI, O_LOAD};

    initial begin
        // Reset state
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_result", out_result, 32'd0);
        check("rst_out_flags", {25'd0, out_rd, out_wb_en, out_illegal}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Basic function, one per cycle with out_ready held high
        rdy_fix = 1'b1;
        issue(O_OP, 3'd0, 7'h00, 5'd3, 32'd5, 32'hFFFFFFFA, 32'd0, 32'd0);
        cyc_setup();
        in_valid = 1'b0;
        #4;
        check("latency_out_valid", {31'd0, out_valid}, 32'd1);
        @(posedge clk);
        issue(O_OP,  3'd0, 7'h20, 5'd4, 32'd5, 32'hFFFFFFFA, 32'd0, 32'd0);
        issue(O_OP,  3'd5, 7'h20, 5'd5, 32'h80000000, 32'd4, 32'd0, 32'd0);
        issue(O_OP,  3'd1, 7'h00, 5'd6, 32'd1, 32'h21, 32'd0, 32'd0);
        issue(O_IMM, 3'd0, 7'h20, 5'd7, 32'h1000, 32'd0, 32'hFFFFF800, 32'd0);
        issue(O_IMM, 3'd5, 7'h20, 5'd8, 32'h80000000, 32'd0, 32'h404, 32'd0);
        issue(O_LUI, 3'd0, 7'h00, 5'd9, 32'd7, 32'd9, 32'h12345000, 32'd0);
        issue(O_AUI, 3'd0, 7'h20, 5'd10, 32'd7, 32'd9, 32'h1000, 32'h100);
        issue(O_OP,  3'd0, 7'h00, 5'd0, 32'd1, 32'd2, 32'd0, 32'd0);
        issue(O_LOAD, 3'd2, 7'h00, 5'd11, 32'd1, 32'd2, 32'd3, 32'd4);
        drain();

        // Back-pressure: A to output, B to skid, C refused
        rdy_fix = 1'b0;
        issue(O_OP, 3'd0, 7'h00, 5'd1, 32'd10, 32'd20, 32'd0, 32'd0);
        issue(O_OP, 3'd4, 7'h00, 5'd2, 32'hF0F0, 32'hFF00, 32'd0, 32'd0);
        for (int k = 0; k < 2; k++) begin
            cyc_setup();
            set_fields(O_OP, 3'd6, 7'h00, 5'd3, 32'h1, 32'h2, 32'd0, 32'd0);
            in_valid = 1'b1;
            #4;
            check("bp_in_ready_full", {31'd0, in_ready}, 32'd0);
            @(posedge clk);
        end
        rdy_fix = 1'b1;
        cyc_setup();
        in_valid = 1'b0;
        #4;
        check("bp_drain_a_valid", {31'd0, out_valid}, 32'd1);
        @(posedge clk);
        cyc_setup();
        #4;
        check("bp_drain_b_valid", {31'd0, out_valid}, 32'd1);
        @(posedge clk);
        cyc_setup();
        #4;
        check("bp_empty_in_ready", {31'd0, in_ready}, 32'd1);
        check("bp_no_third", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        drain();

        // Flush with output and skid full
        rdy_fix = 1'b0;
        issue(O_OP, 3'd0, 7'h00, 5'd1, 32'd1, 32'd1, 32'd0, 32'd0);
        issue(O_OP, 3'd0, 7'h00, 5'd2, 32'd2, 32'd2, 32'd0, 32'd0);
        cyc_setup();
        flush = 1'b1;
        set_fields(O_OP, 3'd0, 7'h00, 5'd3, 32'd3, 32'd3, 32'd0, 32'd0);
        in_valid = 1'b1;
        #4;
        check("flush_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        sbq.delete();
        cyc_setup();
        in_valid = 1'b0;
        #4;
        check("flush_out_valid", {31'd0, out_valid}, 32'd0);
        check("flush_in_ready_after", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        drain();

        // Asynchronous reset mid-stall
        rdy_fix = 1'b0;
        issue(O_OP, 3'd0, 7'h00, 5'd1, 32'd1, 32'd1, 32'd0, 32'd0);
        issue(O_OP, 3'd0, 7'h00, 5'd2, 32'd2, 32'd2, 32'd0, 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("arst_out_valid", {31'd0, out_valid}, 32'd0);
        check("arst_in_ready", {31'd0, in_ready}, 32'd1);
        sbq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        drain();

        // Randomized traffic with random back-pressure and occasional flush
        rdy_rand = 1'b1;
        for (int i = 0; i < 400; i++) begin
            int r;
            r = $urandom_range(0, 29);
            if (r == 0) begin
                cyc_setup();
                flush     = 1'b1;
                out_ready = 1'b0;
                in_valid  = 1'($urandom_range(0, 1));
                #4;
                check("rand_flush_in_ready", {31'd0, in_ready}, 32'd0);
                @(posedge clk);
                sbq.delete();
            end else if (r < 5) begin
                idle(1);
            end else begin
                logic [6:0] f7;
                logic [31:0] v1, v2;
                case ($urandom_range(0, 3))
                    0: f7 = 7'h00;
                    1: f7 = 7'h20;
                    default: f7 = 7'($urandom);
                endcase
                v1 = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
                v2 = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : $urandom;
                issue(opcs[$urandom_range(0, 4)], 3'($urandom), f7, 5'($urandom),
                      v1, v2, $urandom, $urandom);
            end
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
